mem_master: RTL and testbench
=============================

# mem_master

Initiator-side access controller for the 32-bit word-addressed data/instruction memory. It takes single-beat read/write requests from the CPU datapath over a valid/ready handshake and drives the memory's address, write-data and read/write strobes. It captures read data after a fixed latency and returns a one-cycle response with an error flag. It sits between the core's load/store stage and the memory block, and owns all strobe sequencing so the memory sees clean, non-overlapping accesses.

## Interface
- BASE_ADDR, 32'h00400000, byte address of memory word 0
- WORDS, 64, number of 32-bit words in the memory
- RD_LAT, 1, cycles mem_rd is held before data_output is sampled (legal 1..7)

- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- req_valid  in  1  request present
- req_ready  out  1  controller can accept a request
- req_we  in  1  1 = write, 0 = read
- req_addr  in  32  byte address
- req_wdata  in  32  write data
- resp_valid  out  1  one-cycle response pulse
- resp_data  out  32  read data (0 for writes/errors)
- resp_err  out  1  request rejected, no memory access made
- dir  out  32  memory byte address
- data_input  out  32  memory write data
- mem_rd  out  1  memory read strobe
- mem_wd  out  1  memory write strobe
- data_output  in  32  memory read data

## Operation
- FSM states: IDLE, RD, WR, RESP.
- req_ready = 1 only in IDLE (and 0 while rst_n low). Accept = req_valid & req_ready; req_we/req_addr/req_wdata registered at accept.
- Error check at accept: req_addr[1:0] != 0 → error. Errored request: IDLE→RESP directly, no strobe asserted, dir/data_input unchanged.
- Read: IDLE→RD; dir = registered addr, mem_rd = 1 for exactly RD_LAT cycles; data_output sampled at end of last RD cycle into resp_data; RD→RESP.
- Write: IDLE→WR; dir = addr, data_input = wdata, mem_wd = 1 for exactly one cycle; WR→RESP.
- RESP: resp_valid = 1 for one cycle, resp_err per check, strobes 0; RESP→IDLE.
- mem_rd and mem_wd never high in the same cycle. dir and data_input are stable for the full strobe window and the following RESP cycle; both hold their last value in IDLE.
- resp_data/resp_err hold until the next RESP cycle. Write and error responses set resp_data = 0.
- Reset (async): state IDLE, dir = BASE_ADDR, data_input = 0, mem_rd = 0, mem_wd = 0, resp_valid = 0, resp_data = 0, resp_err = 0. Reset mid-transaction drops strobes immediately; the in-flight request is lost and no response is issued.

## Timing
- Accept on edge N (cycle N = accept cycle).
- Read: mem_rd high cycles N+1..N+RD_LAT; resp_valid in cycle N+RD_LAT+1; req_ready high again in N+RD_LAT+2.
- Write: mem_wd high cycle N+1; resp_valid cycle N+2; req_ready high in N+3.
- Error: resp_valid cycle N+1; req_ready high in N+2.
- Max throughput: one read per RD_LAT+2 cycles, one write per 3 cycles. req_valid held high across a busy period is not dropped; it is accepted at the next IDLE cycle.

## Configuration
- MEM_MASTER_RANGE_CHECK_EN defined: an address < BASE_ADDR or >= BASE_ADDR + 4*WORDS is also an error (resp_err = 1, no strobe).
- Not defined: only the alignment check applies. Out-of-range aligned addresses are driven to the memory unchanged.

## Test plan
- Reset; read 0x00400004, RD_LAT=1, memory returns 0x08100006 → mem_rd high one cycle with dir=0x00400004; resp_valid at N+2 with resp_data=0x08100006 and resp_err=0.
- Write 0x00400010 with data 0xDEADBEEF, then read 0x00400010 → mem_wd high exactly one cycle with data_input=0xDEADBEEF and no mem_rd overlap; read returns 0xDEADBEEF.
- Read 0x00400002 → no mem_rd/mem_wd; resp_valid at N+1 with resp_err=1 and resp_data=0.
- With MEM_MASTER_RANGE_CHECK_EN, reads of 0x003FFFFC and 0x00400100 → resp_err=1 with no strobe. Without the macro, the 0x00400100 read asserts mem_rd with dir=0x00400100.
- req_valid held high for three reads at RD_LAT=2 → accepts every 4 cycles; req_ready low during RD/RESP; three responses in order.
- RD_LAT=3, rst_n pulled low in the second RD cycle → mem_rd falls without waiting for clk; no resp_valid; after release a new read completes normally.

Source files
------------

// File: rtl/mem_master.sv
// rtl/mem_master.sv - single-beat read/write access controller for the word-addressed memory
// Optional MEM_MASTER_RANGE_CHECK_EN: also reject addresses outside BASE_ADDR .. BASE_ADDR+4*WORDS-1.
module mem_master #(
  parameter logic [31:0] BASE_ADDR = 32'h00400000,
  parameter int          WORDS     = 64,
  parameter int          RD_LAT    = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_data,
  output logic        resp_err,
  output logic [31:0] dir,
  output logic [31:0] data_input,
  output logic        mem_rd,
  output logic        mem_wd,
  input  logic [31:0] data_output
);

  typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;

  localparam logic [2:0] LAST_CNT = 3'(RD_LAT - 1);

  state_t      r_state;
  logic [2:0]  r_cnt;
  logic [31:0] r_dir;
  logic [31:0] r_data_input;
  logic        r_mem_rd;
  logic        r_mem_wd;
  logic        r_resp_valid;
  logic [31:0] r_resp_data;
  logic        r_resp_err;
  logic        w_accept;
  logic        w_err;

  // Ready is forced low while reset is asserted even though the state already reads IDLE.
  assign req_ready = (r_state == IDLE) && rst_n;
  assign w_accept  = req_valid && req_ready;

`ifdef MEM_MASTER_RANGE_CHECK_EN
  localparam logic [32:0] LIMIT = {1'b0, BASE_ADDR} + (33'(WORDS) * 33'd4);

  always_comb begin
    w_err = (req_addr[1:0] != 2'b00) || (req_addr < BASE_ADDR) ||
            ({1'b0, req_addr} >= LIMIT);
  end
`else
  always_comb begin
    w_err = (req_addr[1:0] != 2'b00);
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_cnt        <= 3'd0;
      r_dir        <= BASE_ADDR;
      r_data_input <= 32'd0;
      r_mem_rd     <= 1'b0;
      r_mem_wd     <= 1'b0;
      r_resp_valid <= 1'b0;
      r_resp_data  <= 32'd0;
      r_resp_err   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            // Rejected requests skip the memory entirely and leave dir/data_input untouched.
            if (w_err) begin
              r_state      <= RESP;
              r_resp_valid <= 1'b1;
              r_resp_err   <= 1'b1;
              r_resp_data  <= 32'd0;
            end else if (req_we) begin
              r_state      <= WR;
              r_dir        <= req_addr;
              r_data_input <= req_wdata;
              r_mem_wd     <= 1'b1;
            end else begin
              r_state  <= RD;
              r_dir    <= req_addr;
              r_mem_rd <= 1'b1;
              r_cnt    <= 3'd0;
            end
          end
        end
        RD: begin
          if (r_cnt == LAST_CNT) begin
            r_state      <= RESP;
            r_mem_rd     <= 1'b0;
            r_resp_valid <= 1'b1;
            r_resp_err   <= 1'b0;
            r_resp_data  <= data_output;
          end else begin
            r_cnt <= r_cnt + 3'd1;
          end
        end
        WR: begin
          r_state      <= RESP;
          r_mem_wd     <= 1'b0;
          r_resp_valid <= 1'b1;
          r_resp_err   <= 1'b0;
          r_resp_data  <= 32'd0;
        end
        RESP: begin
          r_state      <= IDLE;
          r_resp_valid <= 1'b0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign dir        = r_dir;
  assign data_input = r_data_input;
  assign mem_rd     = r_mem_rd;
  assign mem_wd     = r_mem_wd;
  assign resp_valid = r_resp_valid;
  assign resp_data  = r_resp_data;
  assign resp_err   = r_resp_err;

endmodule

// File: tb/tb_mem_master.sv
// tb/tb_mem_master.sv - directed bench for mem_master at RD_LAT 1, 2 and 3
module tb_mem_master;

  localparam logic [31:0] BASE = 32'h00400000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, req_valid, req_we;
  logic [31:0] req_addr, req_wdata;

  logic        rdy1, rv1, re1, mrd1, mwd1;
  logic        rdy2, rv2, re2, mrd2, mwd2;
  logic        rdy3, rv3, re3, mrd3, mwd3;
  logic [31:0] rd1, dir1, di1, do1, off1;
  logic [31:0] rd2, dir2, di2, do2, off2;
  logic [31:0] rd3, dir3, di3, do3, off3;

  logic [31:0] mem [0:63];
  int errors = 0;
  int checks = 0;

  initial for (int i = 0; i < 64; i++) mem[i] = 32'h08100004 + 32'(2 * i);

  assign off1 = dir1 - BASE;
  assign off2 = dir2 - BASE;
  assign off3 = dir3 - BASE;
  assign do1  = (off1 < 32'd256) ? mem[off1[7:2]] : 32'hBAD00000;
  assign do2  = (off2 < 32'd256) ? mem[off2[7:2]] : 32'hBAD00000;
  assign do3  = (off3 < 32'd256) ? mem[off3[7:2]] : 32'hBAD00000;

  always @(posedge clk) if (mwd1 && off1 < 32'd256) mem[off1[7:2]] <= di1;

  mem_master #(.BASE_ADDR(BASE), .WORDS(64), .RD_LAT(1)) u1 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(rdy1), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(rv1), .resp_data(rd1),
    .resp_err(re1), .dir(dir1), .data_input(di1), .mem_rd(mrd1), .mem_wd(mwd1),
    .data_output(do1));

  mem_master #(.BASE_ADDR(BASE), .WORDS(64), .RD_LAT(2)) u2 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(rdy2), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(rv2), .resp_data(rd2),
    .resp_err(re2), .dir(dir2), .data_input(di2), .mem_rd(mrd2), .mem_wd(mwd2),
    .data_output(do2));

  mem_master #(.BASE_ADDR(BASE), .WORDS(64), .RD_LAT(3)) u3 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(rdy3), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(rv3), .resp_data(rd3),
    .resp_err(re3), .dir(dir3), .data_input(di3), .mem_rd(mrd3), .mem_wd(mwd3),
    .data_output(do3));

  // One-cycle request into an idle u1, then six cycles of observation (cycle 1 = N+1).
  task automatic run1(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                      output int rd_n, output int wd_n, output int ov_n, output int rsp_c,
                      output logic [31:0] dir_at, output logic [31:0] di_at,
                      output logic [31:0] rdata, output logic rerr);
    rd_n = 0; wd_n = 0; ov_n = 0; rsp_c = 0;
    dir_at = 32'h0; di_at = 32'h0; rdata = 32'hFFFFFFFF; rerr = 1'bx;
    @(posedge clk); #1;
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata;
    @(posedge clk); #1;
    req_valid = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      if (mrd1) begin rd_n++; dir_at = dir1; end
      if (mwd1) begin wd_n++; dir_at = dir1; di_at = di1; end
      if (mrd1 && mwd1) ov_n++;
      if (rv1 && rsp_c == 0) begin rsp_c = c; rdata = rd1; rerr = re1; end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (rdy1 !== 1'b0) $display("FAIL reset_ready: got %b expected 0", rdy1);
    if (rdy1 !== 1'b0) errors++;
    checks++; if (dir1 !== BASE) begin errors++; $display("FAIL reset_dir: got %h expected %h", dir1, BASE); end
    checks++; if (di1 !== 32'h0) begin errors++; $display("FAIL reset_data_input: got %h expected 0", di1); end
    checks++; if ({mrd1, mwd1} !== 2'b00) begin errors++; $display("FAIL reset_strobes: got %b expected 00", {mrd1, mwd1}); end
    checks++; if ({rv1, re1} !== 2'b00) begin errors++; $display("FAIL reset_resp: got %b expected 00", {rv1, re1}); end
    checks++; if (rd1 !== 32'h0) begin errors++; $display("FAIL reset_resp_data: got %h expected 0", rd1); end
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (rdy1 !== 1'b1) begin errors++; $display("FAIL reset_ready_after: got %b expected 1", rdy1); end
  endtask

  task automatic test_read();
    int rd_n, wd_n, ov_n, rsp_c; logic [31:0] dir_at, di_at, rdata; logic rerr;
    run1(1'b0, 32'h00400004, 32'h0, rd_n, wd_n, ov_n, rsp_c, dir_at, di_at, rdata, rerr);
    checks++; if (rd_n !== 1) begin errors++; $display("FAIL read_rd_cycles: got %0d expected 1", rd_n); end
    checks++; if (wd_n !== 0) begin errors++; $display("FAIL read_wd_cycles: got %0d expected 0", wd_n); end
    checks++; if (dir_at !== 32'h00400004) begin errors++; $display("FAIL read_dir: got %h expected 00400004", dir_at); end
    checks++; if (rsp_c !== 2) begin errors++; $display("FAIL read_resp_cycle: got %0d expected 2", rsp_c); end
    checks++; if (rdata !== 32'h08100006) begin errors++; $display("FAIL read_data: got %h expected 08100006", rdata); end
    checks++; if (rerr !== 1'b0) begin errors++; $display("FAIL read_err: got %b expected 0", rerr); end
  endtask

  task automatic test_write_read();
    int rd_n, wd_n, ov_n, rsp_c; logic [31:0] dir_at, di_at, rdata; logic rerr;
    run1(1'b1, 32'h00400010, 32'hDEADBEEF, rd_n, wd_n, ov_n, rsp_c, dir_at, di_at, rdata, rerr);
    checks++; if (wd_n !== 1) begin errors++; $display("FAIL write_wd_cycles: got %0d expected 1", wd_n); end
    checks++; if (rd_n !== 0 || ov_n !== 0) begin errors++; $display("FAIL write_no_rd: got rd=%0d ov=%0d expected 0 0", rd_n, ov_n); end
    checks++; if (di_at !== 32'hDEADBEEF) begin errors++; $display("FAIL write_data_input: got %h expected deadbeef", di_at); end
    checks++; if (dir_at !== 32'h00400010) begin errors++; $display("FAIL write_dir: got %h expected 00400010", dir_at); end
    checks++; if (rsp_c !== 2 || rerr !== 1'b0 || rdata !== 32'h0) begin
      errors++; $display("FAIL write_resp: got cyc=%0d err=%b data=%h expected 2 0 0", rsp_c, rerr, rdata);
    end
    run1(1'b0, 32'h00400010, 32'h0, rd_n, wd_n, ov_n, rsp_c, dir_at, di_at, rdata, rerr);
    checks++; if (rd_n !== 1 || wd_n !== 0) begin errors++; $display("FAIL readback_strobes: got rd=%0d wd=%0d expected 1 0", rd_n, wd_n); end
    checks++; if (rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL readback_data: got %h expected deadbeef", rdata); end
  endtask

  task automatic test_error();
    int rd_n, wd_n, ov_n, rsp_c; logic [31:0] dir_at, di_at, rdata; logic rerr;
    run1(1'b0, 32'h00400002, 32'h0, rd_n, wd_n, ov_n, rsp_c, dir_at, di_at, rdata, rerr);
    checks++; if (rd_n !== 0 || wd_n !== 0) begin errors++; $display("FAIL err_strobes: got rd=%0d wd=%0d expected 0 0", rd_n, wd_n); end
    checks++; if (rsp_c !== 1) begin errors++; $display("FAIL err_resp_cycle: got %0d expected 1", rsp_c); end
    checks++; if (rerr !== 1'b1) begin errors++; $display("FAIL err_flag: got %b expected 1", rerr); end
    checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL err_data: got %h expected 0", rdata); end
    checks++; if (dir1 !== 32'h00400010) begin errors++; $display("FAIL err_dir_hold: got %h expected 00400010", dir1); end
    checks++; if (re1 !== 1'b1) begin errors++; $display("FAIL err_flag_hold: got %b expected 1", re1); end
  endtask

  task automatic test_range();
    int rd_n, wd_n, ov_n, rsp_c; logic [31:0] dir_at, di_at, rdata; logic rerr;
    run1(1'b0, 32'h00400100, 32'h0, rd_n, wd_n, ov_n, rsp_c, dir_at, di_at, rdata, rerr);
`ifdef MEM_MASTER_RANGE_CHECK_EN
    checks++; if (rd_n !== 0 || rerr !== 1'b1 || rsp_c !== 1) begin
      errors++; $display("FAIL range_high: got rd=%0d err=%b cyc=%0d expected 0 1 1", rd_n, rerr, rsp_c);
    end
`else
    checks++; if (rd_n !== 1 || dir_at !== 32'h00400100 || rerr !== 1'b0) begin
      errors++; $display("FAIL range_high: got rd=%0d dir=%h err=%b expected 1 00400100 0", rd_n, dir_at, rerr);
    end
`endif
    run1(1'b0, 32'h003FFFFC, 32'h0, rd_n, wd_n, ov_n, rsp_c, dir_at, di_at, rdata, rerr);
`ifdef MEM_MASTER_RANGE_CHECK_EN
    checks++; if (rd_n !== 0 || rerr !== 1'b1 || rsp_c !== 1) begin
      errors++; $display("FAIL range_low: got rd=%0d err=%b cyc=%0d expected 0 1 1", rd_n, rerr, rsp_c);
    end
`else
    checks++; if (rd_n !== 1 || dir_at !== 32'h003FFFFC || rerr !== 1'b0) begin
      errors++; $display("FAIL range_low: got rd=%0d dir=%h err=%b expected 1 003ffffc 0", rd_n, dir_at, rerr);
    end
`endif
  endtask

  task automatic test_back_to_back();
    logic [31:0] a [3];
    logic [31:0] exp_d [3];
    logic [31:0] rdat [3];
    int acc [3];
    int rsp [3];
    int n = 0, m = 0, low_n = 0;
    a = '{32'h00400020, 32'h00400024, 32'h00400028};
    exp_d = '{32'h08100014, 32'h08100016, 32'h08100018};
    acc = '{0, 0, 0}; rsp = '{0, 0, 0}; rdat = '{0, 0, 0};
    @(posedge clk); #1;
    req_valid = 1'b1; req_we = 1'b0; req_addr = a[0];
    for (int c = 0; c < 20; c++) begin
      logic took;
      @(negedge clk);
      took = req_valid && rdy2;
      if (rv2 && m < 3) begin rsp[m] = c; rdat[m] = rd2; m++; end
      if (n >= 1 && n < 3 && !rdy2) low_n++;
      if (took) begin acc[n] = c; n++; end
      @(posedge clk); #1;
      if (took) begin
        if (n < 3) req_addr = a[n];
        else req_valid = 1'b0;
      end
    end
    req_valid = 1'b0;
    checks++; if (n !== 3) begin errors++; $display("FAIL b2b_accepts: got %0d expected 3", n); end
    checks++; if (acc[1] - acc[0] !== 4 || acc[2] - acc[1] !== 4) begin
      errors++; $display("FAIL b2b_spacing: got %0d %0d expected 4 4", acc[1] - acc[0], acc[2] - acc[1]);
    end
    checks++; if (low_n !== 6) begin errors++; $display("FAIL b2b_ready_low: got %0d expected 6", low_n); end
    checks++; if (m !== 3) begin errors++; $display("FAIL b2b_resp_count: got %0d expected 3", m); end
    for (int i = 0; i < 3; i++) begin
      checks++; if (rsp[i] !== acc[i] + 3) begin errors++; $display("FAIL b2b_resp_cycle%0d: got %0d expected %0d", i, rsp[i], acc[i] + 3); end
      checks++; if (rdat[i] !== exp_d[i]) begin errors++; $display("FAIL b2b_data%0d: got %h expected %h", i, rdat[i], exp_d[i]); end
    end
  endtask

  task automatic test_reset_mid();
    int rv_n = 0, rd_n = 0, rsp_c = 0;
    logic [31:0] rdata = 32'hFFFFFFFF;
    @(posedge clk); #1;
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h00400004;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++; if (mrd3 !== 1'b1) begin errors++; $display("FAIL mid_rd_before: got %b expected 1", mrd3); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (mrd3 !== 1'b0) begin errors++; $display("FAIL mid_rd_async_drop: got %b expected 0", mrd3); end
    checks++; if (rdy3 !== 1'b0) begin errors++; $display("FAIL mid_ready_in_reset: got %b expected 0", rdy3); end
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (rv3) rv_n++;
      if (mrd3) rd_n++;
    end
    checks++; if (rv_n !== 0 || rd_n !== 0) begin errors++; $display("FAIL mid_no_resp: got resp=%0d rd=%0d expected 0 0", rv_n, rd_n); end
    rd_n = 0;
    @(posedge clk); #1;
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h00400008;
    @(posedge clk); #1;
    req_valid = 1'b0;
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk);
      if (mrd3) rd_n++;
      if (rv3 && rsp_c == 0) begin rsp_c = c; rdata = rd3; end
    end
    checks++; if (rd_n !== 3) begin errors++; $display("FAIL mid_after_rd_cycles: got %0d expected 3", rd_n); end
    checks++; if (rsp_c !== 4) begin errors++; $display("FAIL mid_after_resp_cycle: got %0d expected 4", rsp_c); end
    checks++; if (rdata !== 32'h08100008) begin errors++; $display("FAIL mid_after_data: got %h expected 08100008", rdata); end
  endtask

  initial begin
    test_reset();
    test_read();
    test_write_read();
    test_error();
    test_range();
    repeat (4) @(posedge clk);
    test_back_to_back();
    repeat (6) @(posedge clk);
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
